// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing the shared multicycle CPU datapath with req/ack memory and retire counter
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [5:0]           opcode_i,
  input  logic                 zero_i,
  input  logic                 mem_ack_i,
  output logic                 pc_write_o,
  output logic                 iord_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 ir_write_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic                 reg_write_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic [1:0]           pc_source_o,
  output logic                 illegal_o,
  output logic [3:0]           state_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    IEXEC = 4'd10, IWB = 4'd11, SLTIEX = 4'd12
  } state_t;
  state_t               state_q, state_d;
  logic [5:0]           op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;
  // next state, latched opcode, retire strobe and per-state control outputs
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_source_o  = 2'b00;
    illegal_o    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ack_i;
        pc_write_o  = mem_ack_i;
        state_d     = mem_ack_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        op_d        = opcode_i;
        state_d     = opcode_i == 6'h00 ? EXEC :
                      (opcode_i == 6'h23 || opcode_i == 6'h2B) ? MEMADR :
                      opcode_i == 6'h04 ? BRANCH :
                      opcode_i == 6'h02 ? JUMP :
                      opcode_i == 6'h08 ? IEXEC :
                      opcode_i == 6'h0A ? SLTIEX : FETCH;
        illegal_o   = state_d == FETCH;
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = op_q == 6'h2B ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        state_d   = mem_ack_i ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        retire    = mem_ack_i;
        state_d   = mem_ack_i ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_d     = RWB;
      end
      RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      IEXEC, SLTIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = state_q == SLTIEX ? 3'b011 : 3'b000;
        state_d     = IWB;
      end
      IWB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        pc_source_o = 2'b01;
        pc_write_o  = zero_i;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (rst_i) begin
      pc_write_o  = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
    cnt_d = cnt_q + CNT_WIDTH'(retire);
  end
  // state, latched opcode and retire counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  assign state_o      = state_q;
  assign retire_cnt_o = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl with per-cycle expected state, controls and retire count
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, ack = 1'b0;
  logic [5:0] op = 6'h00;
  logic pcw, iord, req, we, irw, rdst, m2r, rw, asa, ill;
  logic [1:0] asb, ps;
  logic [2:0] aop;
  logic [3:0] st, cnt;
  int errs = 0, checks = 0;
  logic [3:0] exp_ret = 4'd0;
  typedef struct {
    logic       ack, zero, rst;
    logic [5:0] op;
    logic [3:0] st;
    logic [16:0] ctl;
    logic [3:0] ret;
  } ent_t;
  ent_t q[$];
  localparam logic [16:0] F_W  = 17'b0_0_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] F_A  = 17'b1_0_1_0_1_0_0_0_0_01_000_00_0;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_11_000_00_0;
  localparam logic [16:0] MADR = 17'b0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [16:0] MRD  = 17'b0_1_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_0_0_1_1_0_00_000_00_0;
  localparam logic [16:0] MWR  = 17'b0_1_1_1_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] EXE  = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [16:0] RWBC = 17'b0_0_0_0_0_1_0_1_0_00_000_00_0;
  localparam logic [16:0] IEX  = 17'b0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [16:0] SLT  = 17'b0_0_0_0_0_0_0_0_1_10_011_00_0;
  localparam logic [16:0] IWBC = 17'b0_0_0_0_0_0_0_1_0_00_000_00_0;
  localparam logic [16:0] BR   = 17'b0_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [16:0] JMP  = 17'b1_0_0_0_0_0_0_0_0_00_000_10_0;
  localparam logic [16:0] EN   = 17'b1_0_1_1_1_0_0_1_0_00_000_00_1;
  multicycle_ctrl #(.CNT_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(op), .zero_i(zero), .mem_ack_i(ack),
    .pc_write_o(pcw), .iord_o(iord), .mem_req_o(req), .mem_we_o(we), .ir_write_o(irw),
    .reg_dst_o(rdst), .mem_to_reg_o(m2r), .reg_write_o(rw), .alu_src_a_o(asa),
    .alu_src_b_o(asb), .alu_op_o(aop), .pc_source_o(ps), .illegal_o(ill),
    .state_o(st), .retire_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic push(input bit a, input bit z, input bit r, input logic [5:0] o,
                      input logic [3:0] s, input logic [16:0] c, input bit retires);
    ent_t e;
    e.ack = a; e.zero = z; e.rst = r; e.op = o; e.st = s;
    e.ctl = r ? (c & ~EN) : c;
    e.ret = exp_ret;
    q.push_back(e);
    if (retires) exp_ret++;
  endtask
  task automatic instr(input logic [5:0] o, input int fw, input int mw, input bit z);
    bit legal;
    legal = o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0A};
    repeat (fw) push(1'b0, z, 1'b0, o, 4'd0, F_W, 1'b0);
    push(1'b1, z, 1'b0, o, 4'd0, F_A, 1'b0);
    push(1'b1, z, 1'b0, o, 4'd1, DEC | {16'd0, !legal}, 1'b0);
    case (o)
      6'h00: begin
        push(1'b1, z, 1'b0, o, 4'd6, EXE, 1'b0);
        push(1'b1, z, 1'b0, o, 4'd7, RWBC, 1'b1);
      end
      6'h23: begin
        push(1'b1, z, 1'b0, o, 4'd2, MADR, 1'b0);
        repeat (mw) push(1'b0, z, 1'b0, o, 4'd3, MRD, 1'b0);
        push(1'b1, z, 1'b0, o, 4'd3, MRD, 1'b0);
        push(1'b1, z, 1'b0, o, 4'd4, MWB, 1'b1);
      end
      6'h2B: begin
        push(1'b1, z, 1'b0, o, 4'd2, MADR, 1'b0);
        repeat (mw) push(1'b0, z, 1'b0, o, 4'd5, MWR, 1'b0);
        push(1'b1, z, 1'b0, o, 4'd5, MWR, 1'b1);
      end
      6'h04: push(1'b1, z, 1'b0, o, 4'd8, BR | {z, 16'd0}, 1'b1);
      6'h02: push(1'b1, z, 1'b0, o, 4'd9, JMP, 1'b1);
      6'h08: begin
        push(1'b1, z, 1'b0, o, 4'd10, IEX, 1'b0);
        push(1'b1, z, 1'b0, o, 4'd11, IWBC, 1'b1);
      end
      6'h0A: begin
        push(1'b1, z, 1'b0, o, 4'd12, SLT, 1'b0);
        push(1'b1, z, 1'b0, o, 4'd11, IWBC, 1'b1);
      end
      default: ;
    endcase
  endtask
  initial begin
    ent_t e;
    push(1'b0, 1'b0, 1'b1, 6'h00, 4'd0, F_W, 1'b0);
    instr(6'h00, 0, 0, 1'b0);
    instr(6'h23, 2, 2, 1'b0);
    instr(6'h2B, 1, 0, 1'b0);
    instr(6'h04, 0, 0, 1'b0);
    instr(6'h04, 0, 0, 1'b1);
    instr(6'h08, 0, 0, 1'b0);
    instr(6'h0A, 1, 0, 1'b1);
    instr(6'h3F, 0, 0, 1'b0);
    instr(6'h2B, 0, 3, 1'b0);
    push(1'b1, 1'b0, 1'b0, 6'h2B, 4'd0, F_A, 1'b0);
    push(1'b1, 1'b0, 1'b0, 6'h2B, 4'd1, DEC, 1'b0);
    push(1'b1, 1'b0, 1'b0, 6'h2B, 4'd2, MADR, 1'b0);
    push(1'b0, 1'b0, 1'b0, 6'h2B, 4'd5, MWR, 1'b0);
    push(1'b0, 1'b0, 1'b1, 6'h2B, 4'd5, MWR, 1'b0);
    exp_ret = 4'd0;
    for (int i = 0; i < 16; i++) instr(6'h02, 0, 0, 1'b0);
    instr(6'h00, 0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      #1;
      ack = e.ack; zero = e.zero; rst = e.rst; op = e.op;
      @(negedge clk);
      check("state", {28'd0, st}, {28'd0, e.st});
      check("ctrl", {15'd0, pcw, iord, req, we, irw, rdst, m2r, rw, asa, asb, aop, ps, ill}, {15'd0, e.ctl});
      check("retire", {28'd0, cnt}, {28'd0, e.ret});
      @(posedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
